dist_ctrl_fsm: RTL and testbench

- Sequencing controller for the Euclidean distance datapath.
- On a start trigger it walks the two vector BRAMs in chunks of pipeWIDTH elements, driving the BRAM read address and the per-lane read enables.
- It times the accumulator enables against the pipeline latency, then enables the square-root stage until its result is ready and signals completion.
- Sits between the vector loader (start source) and the BRAM pair plus the distance-calculation datapath.

---
 rtl/dist_ctrl_fsm_pkg.sv | 28 ++
 rtl/dist_ctrl_delay.sv | 29 ++
 rtl/dist_ctrl_fsm.sv | 130 +++++++++++++
 tb/tb_dist_ctrl_fsm.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dist_ctrl_fsm_pkg.sv
// Shared types and helpers for the distance-datapath sequencer.
// Holds the controller state encoding and the lane-mask generator.
package dist_ctrl_fsm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      DRAIN,
      SQRT,
      FIN
   } state_t;

   localparam int MAX_LANES = 64;

   // Thermometer mask: lane i is live while i < rem.
   function automatic logic [MAX_LANES-1:0] lane_mask(
      input logic [31:0] rem
   );
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         m[i] = (32'(i) < rem);
      end
      return m;
   endfunction

endpackage

// File: rtl/dist_ctrl_delay.sv
// Fixed-latency delay line aligning feed beats with accumulator input.
// Bit 1 carries feed-valid, bit 0 carries first-beat.
module dist_ctrl_delay #(
   parameter int DEPTH = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] din,
   output logic [1:0] dout,
   output logic       empty
);

   logic [DEPTH-1:0][1:0] sr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr <= '0;
      end else begin
         sr[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            sr[i] <= sr[i-1];
         end
      end
   end

   assign dout  = sr[DEPTH-1];
   assign empty = ~|sr;

endmodule

// File: rtl/dist_ctrl_fsm.sv
// Sequencer for the Euclidean distance datapath: BRAM walk,
// accumulator timing, square-root handshake and completion pulse.
module dist_ctrl_fsm
   import dist_ctrl_fsm_pkg::*;
#(
   parameter int pipeWIDTH = 16,
   parameter int ADD_WIDTH = 12,
   parameter int PIPE_LAT  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          VECTOR_WIDTH,
   input  logic                 STARTCALC,
   input  logic                 RDY_Acc,
   input  logic                 RDY_Sqrt,
   output logic [pipeWIDTH-1:0] EN_Pipe,
   output logic                 EN_Acc,
   output logic                 EN_Sqrt,
   output logic                 RST_Acc,
   output logic                 RST_Sqrt,
   output logic                 PRE_Acc,
   output logic [ADD_WIDTH-1:0] ADDR_RAM,
   output logic                 BUSY,
   output logic                 DONE
);

   state_t                 state;
   logic                   start_q;
   logic                   start;
   logic [31:0]            rem;
   logic [31:0]            step;
   logic [ADD_WIDTH-1:0]   base;
   logic [pipeWIDTH-1:0]   mask;
   logic                   feed_v;
   logic                   first_v;
   logic [1:0]             dly_out;
   logic                   dly_empty;

   always_comb begin
      start = STARTCALC & ~start_q;
      step  = (rem > 32'(pipeWIDTH)) ? 32'(pipeWIDTH) : rem;
      mask  = pipeWIDTH'(lane_mask(rem));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         start_q  <= 1'b0;
         rem      <= '0;
         base     <= '0;
         EN_Pipe  <= '0;
         EN_Sqrt  <= 1'b0;
         RST_Acc  <= 1'b0;
         RST_Sqrt <= 1'b0;
         ADDR_RAM <= '0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         feed_v   <= 1'b0;
         first_v  <= 1'b0;
      end else begin
         start_q  <= STARTCALC;
         RST_Acc  <= 1'b0;
         RST_Sqrt <= 1'b0;
         DONE     <= 1'b0;
         feed_v   <= 1'b0;
         first_v  <= 1'b0;
         EN_Pipe  <= '0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rem      <= VECTOR_WIDTH;
                  base     <= '0;
                  RST_Acc  <= 1'b1;
                  RST_Sqrt <= 1'b1;
                  BUSY     <= 1'b1;
                  state    <= CLEAR;
               end
            end
            // rem already excludes the beat currently on the outputs
            CLEAR, FEED: begin
               if (rem != 32'd0) begin
                  ADDR_RAM <= base;
                  EN_Pipe  <= mask;
                  feed_v   <= 1'b1;
                  first_v  <= (state == CLEAR);
                  rem      <= rem - step;
                  base     <= base + ADD_WIDTH'(pipeWIDTH);
                  state    <= FEED;
               end else begin
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               if (dly_empty && RDY_Acc) begin
                  EN_Sqrt <= 1'b1;
                  state   <= SQRT;
               end
            end
            SQRT: begin
               if (RDY_Sqrt) begin
                  EN_Sqrt <= 1'b0;
                  BUSY    <= 1'b0;
                  DONE    <= 1'b1;
                  state   <= FIN;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   dist_ctrl_delay #(
      .DEPTH (PIPE_LAT)
   ) u_delay (
      .clk   (clk),
      .rst   (rst),
      .din   ({feed_v, first_v}),
      .dout  (dly_out),
      .empty (dly_empty)
   );

   assign EN_Acc  = dly_out[1];
   assign PRE_Acc = dly_out[0];

endmodule

// File: tb/tb_dist_ctrl_fsm.sv
// Scoreboard bench for dist_ctrl_fsm: expected output events are
// queued per run and matched by a negedge monitor with cycle offsets.
module tb_dist_ctrl_fsm;

   localparam int K_CLR  = 0;
   localparam int K_BEAT = 1;
   localparam int K_ACC  = 2;
   localparam int K_SQ   = 3;
   localparam int K_DONE = 4;

   typedef struct {
      int          kind;
      int          t;
      logic [31:0] data;
   } ev_t;

   logic        clk;
   logic        rst;
   logic [31:0] VECTOR_WIDTH;
   logic        STARTCALC;
   logic        RDY_Acc;
   logic        RDY_Sqrt;
   logic [15:0] EN_Pipe;
   logic        EN_Acc;
   logic        EN_Sqrt;
   logic        RST_Acc;
   logic        RST_Sqrt;
   logic        PRE_Acc;
   logic [11:0] ADDR_RAM;
   logic        BUSY;
   logic        DONE;

   ev_t q[$];
   int  n_cmp = 0;
   int  n_bad = 0;
   int  cyc   = 0;
   int  t0    = 0;

   dist_ctrl_fsm #(
      .pipeWIDTH (16),
      .ADD_WIDTH (12),
      .PIPE_LAT  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .VECTOR_WIDTH (VECTOR_WIDTH),
      .STARTCALC    (STARTCALC),
      .RDY_Acc      (RDY_Acc),
      .RDY_Sqrt     (RDY_Sqrt),
      .EN_Pipe      (EN_Pipe),
      .EN_Acc       (EN_Acc),
      .EN_Sqrt      (EN_Sqrt),
      .RST_Acc      (RST_Acc),
      .RST_Sqrt     (RST_Sqrt),
      .PRE_Acc      (PRE_Acc),
      .ADDR_RAM     (ADDR_RAM),
      .BUSY         (BUSY),
      .DONE         (DONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(string nm, logic [63:0] act,
                               logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic void push(int k, int t, logic [31:0] d);
      ev_t e;
      e.kind = k;
      e.t    = t;
      e.data = d;
      q.push_back(e);
   endfunction

   function automatic void got(int k, logic [31:0] d);
      ev_t e;
      n_cmp++;
      if (q.size() == 0) begin
         n_bad++;
         $display("FAIL unexpected: kind %0d t %0d data %0h, none expected",
                  k, cyc - t0, d);
         return;
      end
      e = q.pop_front();
      if (e.kind != k || e.t != cyc - t0 || e.data !== d) begin
         n_bad++;
         $display("FAIL event: got kind %0d t %0d data %0h expected kind %0d t %0d data %0h",
                  k, cyc - t0, d, e.kind, e.t, e.data);
      end
   endfunction

   // Monitor: one event per active output group, in a fixed order.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         if (RST_Acc) begin
            t0 = cyc;
            got(K_CLR, {30'b0, RST_Sqrt, BUSY});
         end
         if (EN_Pipe != 16'h0)
            got(K_BEAT, {4'b0, ADDR_RAM, EN_Pipe});
         if (EN_Acc || PRE_Acc)
            got(K_ACC, {30'b0, EN_Acc, PRE_Acc});
         if (EN_Sqrt)
            got(K_SQ, {31'b0, BUSY});
         if (DONE)
            got(K_DONE, {31'b0, BUSY});
      end
   end

   // Expected event timeline relative to the CLEAR cycle.
   function automatic void push_exp(int vw, int sqw);
      int nb;
      int ts;
      int r;
      logic [11:0] a;
      logic [15:0] m;
      nb = (vw + 15) / 16;
      ts = (nb == 0) ? 2 : nb + 4;
      push(K_CLR, 0, 32'd3);
      for (int t = 1; t <= ts + sqw + 1; t++) begin
         if (t <= nb) begin
            r = vw - (t - 1) * 16;
            a = 12'((t - 1) * 16);
            m = (r >= 16) ? 16'hFFFF : 16'((1 << r) - 1);
            push(K_BEAT, t, {4'b0, a, m});
         end
         if (nb > 0 && t >= 3 && t <= nb + 2)
            push(K_ACC, t, (t == 3) ? 32'd3 : 32'd2);
         if (t >= ts && t <= ts + sqw)
            push(K_SQ, t, 32'd1);
         if (t == ts + sqw + 1)
            push(K_DONE, t, 32'd0);
      end
   endfunction

   task automatic run(input int vw, input int sqw, input bit hold,
                      input bit extra);
      int n;
      push_exp(vw, sqw);
      VECTOR_WIDTH = 32'(vw);
      RDY_Sqrt = (sqw == 0);
      @(posedge clk); #1 STARTCALC = 1'b1;
      @(posedge clk); #1 if (!hold) STARTCALC = 1'b0;
      if (extra) begin
         @(posedge clk); #1 STARTCALC = 1'b1;
         @(posedge clk); #1 STARTCALC = 1'b0;
      end
      if (sqw > 0) begin
         n = 0;
         while (!EN_Sqrt && n < 300) begin
            @(posedge clk); #1 n++;
         end
         chk("sqrt_reached", 64'(EN_Sqrt), 64'd1);
         repeat (sqw) @(posedge clk);
         #1 RDY_Sqrt = 1'b1;
      end
      n = 0;
      while (!DONE && n < 300) begin
         @(posedge clk); #1 n++;
      end
      chk("done_seen", 64'(DONE), 64'd1);
      repeat (12) @(posedge clk);
      #1 chk("sb_empty", 64'(q.size()), 64'd0);
      STARTCALC = 1'b0;
      RDY_Sqrt  = 1'b1;
   endtask

   initial begin
      int n;
      rst          = 1'b0;
      STARTCALC    = 1'b0;
      VECTOR_WIDTH = 32'd0;
      RDY_Acc      = 1'b1;
      RDY_Sqrt     = 1'b1;

      repeat (3) begin
         @(negedge clk);
         chk("rst_outs", 64'({EN_Pipe, EN_Acc, EN_Sqrt, RST_Acc,
                              RST_Sqrt, PRE_Acc, ADDR_RAM, DONE}), 64'd0);
         chk("rst_busy", 64'(BUSY), 64'd0);
      end
      #1 rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("idle_busy", 64'(BUSY), 64'd0);
      end

      run(40, 0, 1'b0, 1'b0);
      run(16, 0, 1'b0, 1'b0);
      run(0, 0, 1'b0, 1'b0);
      run(40, 10, 1'b1, 1'b0);
      run(64, 0, 1'b0, 1'b1);

      // Abort mid-FEED after the second beat.
      push(K_CLR, 0, 32'd3);
      push(K_BEAT, 1, {4'b0, 12'd0, 16'hFFFF});
      push(K_BEAT, 2, {4'b0, 12'd16, 16'hFFFF});
      VECTOR_WIDTH = 32'd64;
      @(posedge clk); #1 STARTCALC = 1'b1;
      @(posedge clk); #1 STARTCALC = 1'b0;
      n = 0;
      while (!(EN_Pipe != 16'h0 && ADDR_RAM == 12'd16) && n < 50) begin
         @(posedge clk); #1 n++;
      end
      chk("beat2_seen", 64'(ADDR_RAM), 64'd16);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("abort_pipe", 64'(EN_Pipe), 64'd0);
      chk("abort_acc", 64'({EN_Acc, PRE_Acc}), 64'd0);
      chk("abort_addr", 64'(ADDR_RAM), 64'd0);
      chk("abort_busy", 64'(BUSY), 64'd0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      repeat (6) @(posedge clk);
      #1 chk("abort_sb", 64'(q.size()), 64'd0);

      run(16, 0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
